// File: rtl/mem_request_initiator.sv
// Single-outstanding initiator for the shared memory responder: holds a request on the bus
// until a served pulse arrives after the settle window, or times out, then returns a response.
module mem_request_initiator #(
   parameter int DATA_W  = 256,
   parameter int ADDR_W  = 5,
   parameter int DEPTH   = 8,
   parameter int SETTLE  = 2,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic              mem_enable,
   output logic              mem_write_en,
   output logic              mem_read_en,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   input  logic              mem_served
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] SETTLE_L  = CNT_W'(SETTLE);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  hold_q, hold_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic addr_oor;
   logic served_ok;

   assign addr_oor  = ({1'b0, cmd_addr} >= DEPTH_L);
   // Served pulses inside the settle window belong to the responder's own cadence.
   assign served_ok = mem_served && (hold_q >= SETTLE_L);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               if (addr_oor) begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = S_RESP;
               end else begin
                  wr_d    = cmd_write;
                  addr_d  = cmd_addr;
                  wdata_d = cmd_wdata;
                  hold_d  = '0;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (served_ok) begin
               rdata_d = wr_q ? '0 : mem_data_out;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (hold_q == HOLD_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Bus outputs are qualified by state so they fall to zero the moment ISSUE ends or reset hits.
   assign cmd_ready    = (state_q == S_IDLE);
   assign mem_enable   = (state_q == S_ISSUE);
   assign mem_write_en = mem_enable &&  wr_q;
   assign mem_read_en  = mem_enable && !wr_q;
   assign mem_address  = mem_enable ? addr_q  : '0;
   assign mem_data_in  = mem_enable ? wdata_q : '0;

   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rsp_valid ? rdata_q : '0;
   assign rsp_error = rsp_valid && err_q;

endmodule
